// File: rtl/cad_display_driver_if.sv
// rtl/cad_display_driver_if.sv - cadence input and multiplexed display output bundle
// master drives cadence and observes the display; slave is the display driver.
interface cad_display_driver_if;
  logic [9:0] cad_in;
  logic [6:0] disp_seg;
  logic [2:0] disp_an;
  logic       busy;

  modport master (
    output cad_in,
    input  disp_seg,
    input  disp_an,
    input  busy
  );

  modport slave (
    input  cad_in,
    output disp_seg,
    output disp_an,
    output busy
  );
endinterface

// File: rtl/cad_display_driver.sv
// rtl/cad_display_driver.sv - cadence to 3-digit multiplexed 7-segment driver
// Serial double-dabble conversion feeds latched digits; a free-running scanner multiplexes them.
module cad_display_driver #(
  parameter int REFRESH_DIV = 32,
  parameter int MAX_DISP    = 999
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cad_display_driver_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  localparam int         RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [9:0] MAX_V = 10'(MAX_DISP);

  logic [1:0]    state_q, state_d;
  logic [9:0]    last_val_q, last_val_d;
  logic [21:0]   shreg_q, shreg_d;
  logic [3:0]    iter_q, iter_d;
  logic          busy_q, busy_d;
  logic [11:0]   dig_q, dig_d;
  logic [1:0]    scan_q, scan_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic [9:0]    sat_val;
  logic [21:0]   adj;
  logic [21:0]   dabbled;
  logic [3:0]    dig_h, dig_t, dig_u;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign sat_val = (bus.cad_in > MAX_V) ? MAX_V : bus.cad_in;
  assign dig_h   = dig_q[11:8];
  assign dig_t   = dig_q[7:4];
  assign dig_u   = dig_q[3:0];

  // Add-3 correction on each BCD nibble, then one shift of the whole register.
  always_comb begin
    adj = shreg_q;
    for (int i = 0; i < 3; i++) begin
      if (adj[10+4*i +: 4] >= 4'd5) begin
        adj[10+4*i +: 4] = adj[10+4*i +: 4] + 4'd3;
      end
    end
    dabbled = adj << 1;
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    shreg_d    = shreg_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    dig_d      = dig_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cad_in != last_val_q) begin
          last_val_d = bus.cad_in;
          shreg_d    = {12'b0, sat_val};
          iter_d     = 4'd0;
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = dabbled;
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dig_d   = shreg_q[21:10];
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ref_d  = (ref_q == REF_LAST) ? '0 : ref_q + 1'b1;
    scan_d = scan_q;
    if (ref_q == REF_LAST) begin
      scan_d = (scan_q == 2'd2) ? 2'd0 : scan_q + 2'd1;
    end
  end

  // Blanked slots keep their enable so the scan duty cycle stays uniform.
  always_comb begin
    seg_d = 7'h00;
    an_d  = 3'b000;
    case (scan_q)
      2'd0: begin
        an_d  = 3'b001;
        seg_d = seg_code(dig_u);
      end
      2'd1: begin
        an_d  = 3'b010;
        seg_d = (dig_h == 4'd0 && dig_t == 4'd0) ? 7'h00 : seg_code(dig_t);
      end
      2'd2: begin
        an_d  = 3'b100;
        seg_d = (dig_h == 4'd0) ? 7'h00 : seg_code(dig_h);
      end
      default: begin
        an_d  = 3'b000;
        seg_d = 7'h00;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      last_val_q <= 10'd0;
      shreg_q    <= 22'd0;
      iter_q     <= 4'd0;
      busy_q     <= 1'b0;
      dig_q      <= 12'd0;
      scan_q     <= 2'd0;
      ref_q      <= '0;
      seg_q      <= 7'h00;
      an_q       <= 3'b000;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      shreg_q    <= shreg_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      dig_q      <= dig_d;
      scan_q     <= scan_d;
      ref_q      <= ref_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.disp_seg = seg_q;
  assign bus.disp_an  = an_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_cad_display_driver.sv
// tb/tb_cad_display_driver.sv - self-checking bench for cad_display_driver
// Reference: displayed number as an integer, digits by division, scan slot from edge count.
module tb_cad_display_driver;
  localparam int RDIV = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   k;
  int   last_raw;

  cad_display_driver_if bus ();

  cad_display_driver #(.REFRESH_DIV(RDIV), .MAX_DISP(999)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int cur_slot();
    return ((k - 1) / RDIV) % 3;
  endfunction

  function automatic logic [2:0] exp_an();
    if (k == 0) return 3'b000;
    return 3'b001 << cur_slot();
  endfunction

  function automatic logic [6:0] exp_seg(input int n);
    if (k == 0) return 7'h00;
    case (cur_slot())
      0: return code_of(n % 10);
      1: return (n < 10) ? 7'h00 : code_of((n / 10) % 10);
      default: return (n < 100) ? 7'h00 : code_of(n / 100);
    endcase
  endfunction

  function automatic int shown_of(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  task automatic check_display(input int n, input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (bus.disp_an !== exp_an()) begin
        errors++;
        $display("FAIL %s an k=%0d: got %b expected %b", name, k, bus.disp_an, exp_an());
      end
      checks++;
      if (bus.disp_seg !== exp_seg(n)) begin
        errors++;
        $display("FAIL %s seg k=%0d: got %h expected %h", name, k, bus.disp_seg, exp_seg(n));
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s idle busy k=%0d: got %b expected 0", name, k, bus.busy);
      end
    end
  endtask

  task automatic convert(input int v, input string name);
    bit trig;
    trig = (v != last_raw);
    @(negedge clk);
    bus.cad_in = v[9:0];
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== trig) begin
        errors++;
        $display("FAIL %s busy j=%0d: got %b expected %b", name, j, bus.busy, trig);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy end: got %b expected 0", name, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.disp_seg !== exp_seg(shown_of(v))) begin
      errors++;
      $display("FAIL %s latency seg: got %h expected %h", name, bus.disp_seg, exp_seg(shown_of(v)));
    end
    last_raw = v;
    check_display(shown_of(v), 3 * RDIV + 4, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cad_in = 10'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.disp_seg !== 7'h00 || bus.disp_an !== 3'b000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got seg=%h an=%b busy=%b expected 00 000 0",
               bus.disp_seg, bus.disp_an, bus.busy);
    end
    rst = 1'b0;
    last_raw = 0;
    check_display(0, 3 * RDIV + 8, "reset_zero");
  endtask

  task automatic test_basic();
    convert(87, "val87");
  endtask

  task automatic test_no_blank_tens();
    convert(105, "val105");
  endtask

  task automatic test_saturation();
    convert(1023, "sat1023");
    convert(1023, "sat_hold");
    convert(1000, "sat1000");
  endtask

  task automatic test_back_to_back();
    int highs;
    int pulses;
    logic prev;
    highs = 0;
    pulses = 0;
    prev = 1'b0;
    @(negedge clk);
    bus.cad_in = 10'd60;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) highs++;
      if (bus.busy === 1'b1 && prev === 1'b0) pulses++;
      prev = bus.busy;
      if (j == 11) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b gap busy: got %b expected 0", bus.busy);
        end
      end
      if (j == 12) begin
        checks++;
        if (bus.disp_seg !== exp_seg(60)) begin
          errors++;
          $display("FAIL b2b first value seg: got %h expected %h", bus.disp_seg, exp_seg(60));
        end
      end
      if (j == 2) bus.cad_in = 10'd120;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b pulses: got %0d expected 2", pulses);
    end
    checks++;
    if (highs != 22) begin
      errors++;
      $display("FAIL b2b busy cycles: got %0d expected 22", highs);
    end
    last_raw = 120;
    check_display(120, 3 * RDIV + 4, "b2b_final");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cad_in = 10'd250;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.disp_seg !== 7'h00 || bus.disp_an !== 3'b000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset async: got seg=%h an=%b busy=%b expected 00 000 0",
               bus.disp_seg, bus.disp_an, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== (j <= 11)) begin
        errors++;
        $display("FAIL midreset busy j=%0d: got %b expected %b", j, bus.busy, (j <= 11));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.disp_seg !== exp_seg(250)) begin
      errors++;
      $display("FAIL midreset latency seg: got %h expected %h", bus.disp_seg, exp_seg(250));
    end
    last_raw = 250;
    check_display(250, 3 * RDIV + 4, "midreset");
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 8; i++) begin
      v = (i == 3) ? last_raw : int'($urandom_range(0, 1023));
      convert(v, "random");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last_raw = 0;
    rst = 1'b1;
    bus.cad_in = 10'd0;
    test_reset();
    test_basic();
    test_no_blank_tens();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
